// File: rtl/clic_reg_pkg.sv
// Shared CLIC constants and gateway state type.
// SrcW also sizes the core-side acknowledge index.
package clic_reg_pkg;

    localparam int unsigned NumSrc = 32;
    localparam int unsigned SrcW   = $clog2(NumSrc);

    typedef enum logic {
        GW_IDLE = 1'b0,
        GW_PEND = 1'b1
    } gw_state_e;

endpackage

// File: rtl/clic_gateway_cell.sv
// One interrupt source: input synchronizer, previous-sample flop and pending state.
// Level mode mirrors the synchronized line; edge mode latches rises until cleared.
module clic_gateway_cell
    import clic_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic le_i,
    input  logic sw_set_i,
    input  logic sw_clr_i,
    input  logic ack_i,
    output logic ip_o
);

    logic      sync;
    logic      prev;
    logic      rise;
    gw_state_e state;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign sync = src_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sreg;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sreg <= '0;
            end else begin
                sreg[0] <= src_i;
                for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                    sreg[k] <= sreg[k-1];
                end
            end
        end

        assign sync = sreg[SYNC_STAGES-1];
    end

    assign rise = sync & ~prev;

    // Set outranks clear so a rise coinciding with an ack is never dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev  <= 1'b0;
            state <= GW_IDLE;
        end else begin
            prev <= sync;
            if (!le_i) begin
                state <= sync ? GW_PEND : GW_IDLE;
            end else if (rise || sw_set_i) begin
                state <= GW_PEND;
            end else if (ack_i || sw_clr_i) begin
                state <= GW_IDLE;
            end
        end
    end

    assign ip_o = (state == GW_PEND);

endmodule

// File: rtl/clic_gateway.sv
// Per-source interrupt gateway producing the pending vector for the CLIC register block.
// Acknowledge ids outside the source range decode to no hit.
module clic_gateway
    import clic_reg_pkg::*;
#(
    parameter int unsigned N_SOURCE    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] sw_set_i,
    input  logic [N_SOURCE-1:0] sw_clr_i,
    input  logic                ack_valid_i,
    input  logic [SrcW-1:0]     ack_id_i,
    output logic [N_SOURCE-1:0] ip_o
);

    logic [N_SOURCE-1:0] ack_hit;

    always_comb begin
        ack_hit = '0;
        for (int unsigned i = 0; i < N_SOURCE; i++) begin
            if (ack_valid_i && (32'(ack_id_i) == i)) begin
                ack_hit[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_SOURCE; g++) begin : g_cell
        clic_gateway_cell #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .src_i   (intr_src_i[g]),
            .le_i    (le_i[g]),
            .sw_set_i(sw_set_i[g]),
            .sw_clr_i(sw_clr_i[g]),
            .ack_i   (ack_hit[g]),
            .ip_o    (ip_o[g])
        );
    end

endmodule

// File: tb/tb_clic_gateway.sv
// Self-checking bench: a 32-source and a 24-source gateway share stimulus and are
// compared every cycle against a history-based model, plus directed literal checks.
module tb_clic_gateway;
    import clic_reg_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     src = '0;
    logic [31:0]     le = '1;
    logic [31:0]     sw_set = '0;
    logic [31:0]     sw_clr = '0;
    logic            ack_valid = 1'b0;
    logic [SrcW-1:0] ack_id = '0;
    logic [31:0]     ip32;
    logic [23:0]     ip24;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    clic_gateway #(.N_SOURCE(32), .SYNC_STAGES(2)) dut32 (
        .clk_i(clk), .rst_i(rst), .intr_src_i(src), .le_i(le),
        .sw_set_i(sw_set), .sw_clr_i(sw_clr), .ack_valid_i(ack_valid),
        .ack_id_i(ack_id), .ip_o(ip32)
    );

    clic_gateway #(.N_SOURCE(24), .SYNC_STAGES(2)) dut24 (
        .clk_i(clk), .rst_i(rst), .intr_src_i(src[23:0]), .le_i(le[23:0]),
        .sw_set_i(sw_set[23:0]), .sw_clr_i(sw_clr[23:0]), .ack_valid_i(ack_valid),
        .ack_id_i(ack_id), .ip_o(ip24)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: h[k] is the raw line sampled k clock edges ago; with two sync
    // stages the synchronized value is h[2] and its previous sample h[3].
    logic [31:0] h [1:3];
    logic [31:0] exp32;
    logic [23:0] exp24;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h[1] <= '0; h[2] <= '0; h[3] <= '0;
            exp32 <= '0;
            exp24 <= '0;
        end else begin
            automatic logic [31:0] n32 = exp32;
            automatic logic [23:0] n24 = exp24;
            automatic logic [31:0] s = h[2];
            automatic logic [31:0] p = h[3];
            for (int i = 0; i < 32; i++) begin
                automatic logic set_ev = (s[i] && !p[i]) || sw_set[i];
                automatic logic clr_ev = (ack_valid && int'(ack_id) == i) || sw_clr[i];
                if (!le[i])      n32[i] = s[i];
                else if (set_ev) n32[i] = 1'b1;
                else if (clr_ev) n32[i] = 1'b0;
                if (i < 24) begin
                    if (!le[i])      n24[i] = s[i];
                    else if (set_ev) n24[i] = 1'b1;
                    else if (clr_ev) n24[i] = 1'b0;
                end
            end
            exp32 <= n32;
            exp24 <= n24;
            h[1] <= src;
            h[2] <= h[1];
            h[3] <= h[2];
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_ip32", ip32, exp32);
        chk("model_ip24", {8'h00, ip24}, {8'h00, exp24});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(3);
        chk("reset_ip32", ip32, 32'h0);
        chk("reset_ip24", {8'h00, ip24}, 32'h0);
        rst = 1'b0;
        step(2);

        // Edge latency on source 3, then ack with line held high
        src[3] = 1'b1;
        step(2); chk("edge3_before", 32'(ip32[3]), 32'd0);
        step(1); chk("edge3_set", 32'(ip32[3]), 32'd1);
        step(4);
        ack_valid = 1'b1; ack_id = 5'd3;
        step(1); ack_valid = 1'b0;
        chk("edge3_ack", 32'(ip32[3]), 32'd0);
        step(5); chk("edge3_held", 32'(ip32[3]), 32'd0);
        src[3] = 1'b0;
        step(3);

        // Level source 5 ignores ack and sw_clr
        le[5] = 1'b0;
        src[5] = 1'b1;
        step(3); chk("lvl5_high", 32'(ip32[5]), 32'd1);
        ack_valid = 1'b1; ack_id = 5'd5; sw_clr[5] = 1'b1;
        step(1); chk("lvl5_ack_ignored", 32'(ip32[5]), 32'd1);
        ack_valid = 1'b0; sw_clr[5] = 1'b0;
        step(1); src[5] = 1'b0;
        step(2); chk("lvl5_tail", 32'(ip32[5]), 32'd1);
        step(1); chk("lvl5_low", 32'(ip32[5]), 32'd0);
        step(2);

        // Rise on source 7 collides with ack and sw_clr
        src[7] = 1'b1;
        step(2);
        ack_valid = 1'b1; ack_id = 5'd7; sw_clr[7] = 1'b1;
        step(1);
        ack_valid = 1'b0; sw_clr[7] = 1'b0;
        chk("collide7", 32'(ip32[7]), 32'd1);
        src[7] = 1'b0;
        step(3);

        // Software pend and clear on source 0, then level-mode set ignored
        sw_set[0] = 1'b1; step(1); sw_set[0] = 1'b0;
        chk("sw_set0", 32'(ip32[0]), 32'd1);
        sw_clr[0] = 1'b1; step(1); sw_clr[0] = 1'b0;
        chk("sw_clr0", 32'(ip32[0]), 32'd0);
        le[0] = 1'b0;
        sw_set[0] = 1'b1; step(1); sw_set[0] = 1'b0;
        chk("sw_set0_level", 32'(ip32[0]), 32'd0);
        step(1);

        // Out-of-range ack on the 24-source gateway
        le = '1;
        sw_set = '1; step(1); sw_set = '0;
        chk("all_pend32", ip32, 32'hFFFF_FFFF);
        chk("all_pend24", {8'h00, ip24}, 32'h00FF_FFFF);
        ack_valid = 1'b1; ack_id = 5'd30; step(1); ack_valid = 1'b0;
        chk("oor_ack24", {8'h00, ip24}, 32'h00FF_FFFF);
        chk("ack30_ip32", ip32, 32'hBFFF_FFFF);
        step(2);

        // Mixed random traffic, including mode switches
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) le = $urandom();
            src = src ^ ($urandom() & $urandom() & $urandom());
            sw_set = $urandom() & $urandom() & $urandom() & $urandom();
            sw_clr = $urandom() & $urandom() & $urandom();
            ack_valid = $urandom_range(0, 1) == 1;
            ack_id = 5'($urandom_range(0, 31));
            step(1);
        end
        src = '0; sw_set = '0; sw_clr = '0; ack_valid = 1'b0;
        step(4);

        // Asynchronous reset mid-run with all sources pending and lines toggling
        le = '1;
        sw_set = '1; step(1); sw_set = '0;
        chk("pre_rst32", ip32, 32'hFFFF_FFFF);
        src = 32'hA5A5_A5A5;
        step(1);
        src = ~src;
        #2 rst = 1'b1;
        #1;
        chk("async_rst32", ip32, 32'h0);
        chk("async_rst24", {8'h00, ip24}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step(1); src = ~src;
        end
        src = '0;
        step(1); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("post_rst32", ip32, 32'h0);
        end
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
